// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU reservation station: operand/entry records, the
// registered ALU input bundle and the ALU control encodings.
package alu_issue_queue_pkg;

    localparam int TAG_W = 6;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRA = 4'b1110;

    typedef struct packed {
        logic [31:0]      val;
        logic [TAG_W-1:0] tag;
        logic             rdy;
    } srcOperandStruct;

    typedef struct packed {
        logic [3:0]       ALUCtrl;
        logic             ALUSrc;
        logic [31:0]      imm;
        srcOperandStruct  src1;
        srcOperandStruct  src2;
        logic [TAG_W-1:0] dest_tag;
    } rsEntryStruct;

    typedef struct packed {
        logic        valid;
        logic [3:0]  ALUCtrl;
        logic        ALUSrc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } aluInStruct;

    // A waiting operand whose tag matches the broadcast takes the CDB value.
    function automatic srcOperandStruct wake_src(input srcOperandStruct s,
                                                 input logic cdb_valid,
                                                 input logic [TAG_W-1:0] cdb_tag,
                                                 input logic [31:0] cdb_value);
        srcOperandStruct r;
        r = s;
        if (cdb_valid && !s.rdy && (s.tag == cdb_tag)) begin
            r.val = cdb_value;
            r.rdy = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch handshake and CDB broadcast bundle seen by the ALU issue queue.
interface alu_issue_queue_if;
    import alu_issue_queue_pkg::*;

    logic             disp_valid;
    logic             disp_ready;
    rsEntryStruct     disp_entry;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;

    modport master (output disp_valid, disp_entry, cdb_valid, cdb_tag, cdb_value,
                    input  disp_ready);
    modport slave  (input  disp_valid, disp_entry, cdb_valid, cdb_tag, cdb_value,
                    output disp_ready);
endinterface

// File: rtl/alu_issue_queue_oldest_ready_select.sv
// Combinational oldest-first pick: age[i][j]=1 means entry i was dispatched before j.
module oldest_ready_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
    output logic [DEPTH-1:0]            grant,
    output logic                        found
);
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if ((j != i) && ready[j] && !age[i][j])
                    grant[i] = 1'b0;
            end
        end
        found = |ready;
    end
endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: holds dispatched ops, captures CDB results and
// issues the oldest ready op into a registered ALU input each cycle.
module alu_issue_queue
    import alu_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_issue_queue_if.slave         bus,
    input  logic                     issue_stall,
    input  logic                     flush,
    output aluInStruct               aluIn,
    output logic [TAG_W-1:0]         issue_tag,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = IDX_W + 1;

    rsEntryStruct                entry_q [DEPTH];
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][DEPTH-1:0] age_q;

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic             found;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic             do_issue;
    rsEntryStruct     disp_woken;

    always_comb begin
        occupancy = '0;
        ready     = '0;
        free_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
            ready[i]  = valid_q[i] && entry_q[i].src1.rdy &&
                        (entry_q[i].src2.rdy || entry_q[i].ALUSrc);
            if (!valid_q[i])
                free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i])
                sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        disp_woken      = bus.disp_entry;
        disp_woken.src1 = wake_src(bus.disp_entry.src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
        disp_woken.src2 = wake_src(bus.disp_entry.src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    end

    oldest_ready_select #(.DEPTH(DEPTH)) u_select (
        .ready (ready),
        .age   (age_q),
        .grant (grant),
        .found (found)
    );

    // Readiness uses pre-flush occupancy; flush only blocks the actual write.
    assign bus.disp_ready = (occupancy < OCC_W'(DEPTH));
    assign accept         = bus.disp_valid && bus.disp_ready && !flush;
    assign do_issue       = found && !issue_stall && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            age_q   <= '0;
            for (int i = 0; i < DEPTH; i++)
                entry_q[i] <= '0;
        end else if (flush) begin
            valid_q <= '0;
            age_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i]) begin
                    entry_q[i].src1 <= wake_src(entry_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                    entry_q[i].src2 <= wake_src(entry_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
                end
            end
            if (do_issue)
                valid_q[sel_idx] <= 1'b0;
            // New entry is younger than every entry currently held.
            if (accept) begin
                valid_q[free_idx] <= 1'b1;
                entry_q[free_idx] <= disp_woken;
                for (int j = 0; j < DEPTH; j++) begin
                    age_q[free_idx][j] <= 1'b0;
                    age_q[j][free_idx] <= valid_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluIn     <= '0;
            issue_tag <= '0;
        end else if (flush) begin
            aluIn.valid <= 1'b0;
        end else if (!issue_stall) begin
            if (found) begin
                aluIn.valid   <= 1'b1;
                aluIn.ALUCtrl <= entry_q[sel_idx].ALUCtrl;
                aluIn.ALUSrc  <= entry_q[sel_idx].ALUSrc;
                aluIn.imm     <= entry_q[sel_idx].imm;
                aluIn.rs1     <= entry_q[sel_idx].src1.val;
                aluIn.rs2     <= entry_q[sel_idx].src2.val;
                issue_tag     <= entry_q[sel_idx].dest_tag;
            end else begin
                aluIn.valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: directed dispatch/CDB sequences push
// expected issues; a negedge monitor pops and compares each new issue.
module tb_alu_issue_queue;
    import alu_issue_queue_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_stall = 1'b0;
    logic             flush = 1'b0;
    aluInStruct       aluIn;
    logic [TAG_W-1:0] issue_tag;
    logic [2:0]       occupancy;

    alu_issue_queue_if bus();

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .issue_stall (issue_stall),
        .flush       (flush),
        .aluIn       (aluIn),
        .issue_tag   (issue_tag),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       ctrl;
        logic             alusrc;
        logic [31:0]      imm;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rsEntryStruct mk(input logic [3:0] ctrl, input logic alusrc, input logic [31:0] imm,
                                        input logic [31:0] v1, input logic [TAG_W-1:0] t1, input logic r1,
                                        input logic [31:0] v2, input logic [TAG_W-1:0] t2, input logic r2,
                                        input logic [TAG_W-1:0] dest);
        rsEntryStruct e;
        e.ALUCtrl  = ctrl;
        e.ALUSrc   = alusrc;
        e.imm      = imm;
        e.src1.val = v1;
        e.src1.tag = t1;
        e.src1.rdy = r1;
        e.src2.val = v2;
        e.src2.tag = t2;
        e.src2.rdy = r2;
        e.dest_tag = dest;
        return e;
    endfunction

    function automatic exp_t ex(input logic [3:0] ctrl, input logic alusrc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2, input logic [TAG_W-1:0] tag);
        exp_t e;
        e.ctrl   = ctrl;
        e.alusrc = alusrc;
        e.imm    = imm;
        e.rs1    = rs1;
        e.rs2    = rs2;
        e.tag    = tag;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A held aluIn during stall is not a new issue; only edges with stall low load one.
    logic stall_at_edge = 1'b0;
    always @(posedge clk) stall_at_edge = issue_stall;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && aluIn.valid && !stall_at_edge) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got issue_tag %0d expected no issue", issue_tag);
            end else begin
                e = exp_q.pop_front();
                check("issue_alu_ctrl", aluIn.ALUCtrl, e.ctrl);
                check("issue_alu_src", aluIn.ALUSrc, e.alusrc);
                check("issue_imm", aluIn.imm, e.imm);
                check("issue_rs1", aluIn.rs1, e.rs1);
                if (!e.alusrc)
                    check("issue_rs2", aluIn.rs2, e.rs2);
                check("issue_tag", issue_tag, e.tag);
            end
        end
    end

    int         order [4] = '{2, 0, 1, 3};
    aluInStruct snap;
    logic [TAG_W-1:0] snap_tag;

    initial begin
        bus.disp_valid = 1'b0;
        bus.disp_entry = '0;
        bus.cdb_valid  = 1'b0;
        bus.cdb_tag    = '0;
        bus.cdb_value  = '0;

        // Reset values
        repeat (2) step();
        check("rst_alu_in", aluIn, '0);
        check("rst_issue_tag", issue_tag, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_disp_ready", bus.disp_ready, 1);
        rst_n = 1'b1;
        step();

        // Ready ADD: accept at edge N, issue at edge N+1
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_ADD, 0, 0, 5, 0, 1, 7, 0, 1, 3);
        exp_q.push_back(ex(ALU_ADD, 0, 0, 5, 7, 3));
        step();
        bus.disp_valid = 1'b0;
        check("t1_occ_after_accept", occupancy, 1);
        check("t1_valid_before_issue", aluIn.valid, 0);
        step();
        check("t1_valid_issued", aluIn.valid, 1);
        check("t1_occ_after_issue", occupancy, 0);
        step();

        // A waits on tag 9, B ready; B issues first, A after the broadcast
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_SUB, 0, 0, 20, 0, 1, 0, 9, 0, 4);
        step();
        bus.disp_entry = mk(ALU_OR, 0, 0, 3, 0, 1, 12, 0, 1, 5);
        exp_q.push_back(ex(ALU_OR, 0, 0, 3, 12, 5));
        exp_q.push_back(ex(ALU_SUB, 0, 0, 20, 32'h10, 4));
        step();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = 9;
        bus.cdb_value  = 32'h10;
        step();
        bus.cdb_valid = 1'b0;
        check("t2_b_first", issue_tag, 5);
        step();
        check("t2_a_second", issue_tag, 4);
        check("t2_a_rs2", aluIn.rs2, 32'h10);
        step();

        // Fill all four slots with waiting ops; a fifth is refused
        for (int k = 0; k < 4; k++) begin
            bus.disp_valid = 1'b1;
            bus.disp_entry = mk(ALU_ADD, 1, 100 + k, 0, TAG_W'(20 + k), 0, 0, 63, 0, TAG_W'(16 + k));
            step();
        end
        check("t3_occ_full", occupancy, 4);
        check("t3_ready_full", bus.disp_ready, 0);
        bus.disp_entry = mk(ALU_XOR, 0, 0, 1, 0, 1, 2, 0, 1, 40);
        step();
        bus.disp_valid = 1'b0;
        check("t3_occ_after_refuse", occupancy, 4);
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(ex(ALU_ADD, 1, 100 + order[n], 32'h200 + 20 + order[n], 0, TAG_W'(16 + order[n])));
            bus.cdb_valid = 1'b1;
            bus.cdb_tag   = TAG_W'(20 + order[n]);
            bus.cdb_value = 32'h200 + 20 + order[n];
            step();
        end
        bus.cdb_valid = 1'b0;
        step();
        check("t3_drained", occupancy, 0);
        step();

        // Stall holds aluIn; older C then younger D (D lands in a lower slot)
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_ADD, 0, 0, 1, 0, 1, 2, 0, 1, 11);
        exp_q.push_back(ex(ALU_ADD, 0, 0, 1, 2, 11));
        step();
        bus.disp_entry = mk(ALU_AND, 0, 0, 32'hF0, 0, 1, 32'h3C, 0, 1, 12);
        exp_q.push_back(ex(ALU_AND, 0, 0, 32'hF0, 32'h3C, 12));
        step();
        bus.disp_entry = mk(ALU_XOR, 0, 0, 32'hAA, 0, 1, 32'h55, 0, 1, 13);
        exp_q.push_back(ex(ALU_XOR, 0, 0, 32'hAA, 32'h55, 13));
        issue_stall = 1'b1;
        snap     = aluIn;
        snap_tag = issue_tag;
        check("t4_e_issued", issue_tag, 11);
        step();
        bus.disp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("t4_stall_hold_alu_in", aluIn, snap);
            check("t4_stall_hold_tag", issue_tag, snap_tag);
            if (c < 2) step();
        end
        check("t4_occ_stalled", occupancy, 2);
        issue_stall = 1'b0;
        step();
        check("t4_older_first", issue_tag, 12);
        step();
        check("t4_younger_second", issue_tag, 13);
        step();

        // Same-cycle CDB match on a dispatching op
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_SRA, 0, 0, 0, 30, 0, 2, 0, 1, 20);
        bus.cdb_valid  = 1'b1;
        bus.cdb_tag    = 30;
        bus.cdb_value  = 32'h55;
        exp_q.push_back(ex(ALU_SRA, 0, 0, 32'h55, 2, 20));
        step();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        step();
        check("t5_issued", aluIn.valid, 1);
        check("t5_tag", issue_tag, 20);
        step();

        // Flush beats a pending issue and a same-cycle dispatch
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_ADD, 0, 0, 9, 0, 1, 9, 0, 1, 41);
        step();
        flush = 1'b1;
        bus.disp_entry = mk(ALU_ADD, 0, 0, 1, 0, 1, 1, 0, 1, 42);
        check("t6_ready_preflush", bus.disp_ready, 1);
        step();
        flush = 1'b0;
        bus.disp_valid = 1'b0;
        check("t6_occ_flushed", occupancy, 0);
        check("t6_valid_flushed", aluIn.valid, 0);
        step();
        check("t6_no_late_issue", aluIn.valid, 0);

        // Asynchronous reset mid-stream
        bus.disp_valid = 1'b1;
        bus.disp_entry = mk(ALU_XOR, 0, 0, 6, 0, 1, 3, 0, 1, 50);
        exp_q.push_back(ex(ALU_XOR, 0, 0, 6, 3, 50));
        step();
        bus.disp_entry = mk(ALU_ADD, 0, 0, 0, 33, 0, 1, 0, 1, 51);
        step();
        bus.disp_valid = 1'b0;
        check("t7_occ_pre_reset", occupancy, 1);
        check("t7_valid_pre_reset", aluIn.valid, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_alu_in", aluIn, '0);
        check("t7_rst_tag", issue_tag, 0);
        check("t7_rst_occ", occupancy, 0);
        check("t7_rst_ready", bus.disp_ready, 1);
        step();
        rst_n = 1'b1;
        step();
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = 33;
        bus.cdb_value = 32'h77;
        step();
        bus.cdb_valid = 1'b0;
        step();
        check("t7_entry_dropped", aluIn.valid, 0);
        step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
